ofb_pt_serializer: RTL and testbench

//  Downstream of the OFB decrypt stage. Captures each 128-bit plaintext block on the dec_done pulse,

---
 rtl/ofb_pt_serializer_pkg.sv | 30 +++
 rtl/ofb_blk_fifo.sv | 72 +++++++
 rtl/ofb_pt_serializer.sv | 197 +++++++++++++++++++
 tb/tb_ofb_pt_serializer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofb_pt_serializer_pkg.sv
// Shared widths, FIFO entry layout and FSM encodings for the OFB plaintext serializer.
package ofb_pt_serializer_pkg;

  localparam int BLK_W   = 128;
  localparam int BYTE_W  = 8;
  localparam int NB_W    = 5;
  localparam int ENTRY_W = BLK_W + 1 + NB_W;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  localparam logic [NB_W-1:0] NB_FULL = 5'd16;

  typedef struct packed {
    logic [BLK_W-1:0] data;
    logic             last;
    logic [NB_W-1:0]  nbytes;
  } fifo_entry_t;

  function automatic fifo_entry_t make_entry(input logic [BLK_W-1:0] data,
                                             input logic             last,
                                             input logic [NB_W-1:0]  nbytes);
    fifo_entry_t e;
    e.data   = data;
    e.last   = last;
    e.nbytes = nbytes;
    return e;
  endfunction

endpackage

// File: rtl/ofb_blk_fifo.sv
// DEPTH-entry synchronous block FIFO; a push while full is taken only alongside a pop.
module ofb_blk_fifo
  import ofb_pt_serializer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               push,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               full,
  output logic               empty
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic               do_push;
  logic               do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointers and storage contents.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = wr_data;
        wr_ptr_d                = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // Pointer and storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/ofb_pt_serializer.sv
// OFB plaintext serializer: buffers decrypted 128-bit blocks and streams them MSB byte first.
// Build macro PKCS7_STRIP_EN enables PKCS#7 pad stripping/checking on last blocks.
module ofb_pt_serializer
  import ofb_pt_serializer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             blk_valid,
  input  logic [BLK_W-1:0] blk_data,
  input  logic             blk_last,
  output logic [BYTE_W-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             msg_done,
  output logic             overflow,
  output logic             pad_err
);

  logic [0:0]         state_q, state_d;
  logic [BLK_W-1:0]   shift_q, shift_d;
  logic [NB_W-1:0]    cnt_q, cnt_d;
  logic [NB_W-1:0]    nbytes_in;
  logic               last_q, last_d;
  logic               m_last_q, m_last_d;
  logic               msg_done_q, msg_done_d;
  logic               overflow_q, overflow_d;
  logic               accept;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_wr_data;
  logic [ENTRY_W-1:0] fifo_rd_data;
  fifo_entry_t        head;

  assign head         = fifo_rd_data;
  assign fifo_wr_data = make_entry(blk_data, blk_last, nbytes_in);

  ofb_blk_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .push    (push),
    .wr_data (fifo_wr_data),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef PKCS7_STRIP_EN
  logic [BYTE_W-1:0] pad;
  logic              pad_ok;
  logic              pad_err_q, pad_err_d;

  // PKCS#7 trailer check on the incoming block; only last blocks are ever stripped.
  always_comb begin
    pad    = blk_data[BYTE_W-1:0];
    pad_ok = (pad >= 8'd1) && (pad <= 8'd16);
    for (int i = 0; i < 16; i++) begin
      pad_ok = pad_ok && !((8'(i) < pad) && (blk_data[i*BYTE_W +: BYTE_W] != pad));
    end
    if (blk_last && pad_ok) begin
      nbytes_in = NB_FULL - pad[NB_W-1:0];
    end else begin
      nbytes_in = NB_FULL;
    end
    if (clr) begin
      pad_err_d = 1'b0;
    end else if (push && blk_last && !pad_ok) begin
      pad_err_d = 1'b1;
    end else begin
      pad_err_d = pad_err_q;
    end
  end

  // Sticky pad error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_err_q <= 1'b0;
    end else begin
      pad_err_q <= pad_err_d;
    end
  end

  assign pad_err = pad_err_q;
`else
  assign nbytes_in = NB_FULL;
  assign pad_err   = 1'b0;
`endif

  // Block FSM: load from FIFO, shift bytes out, chain the next block without a bubble.
  always_comb begin
    accept     = (state_q == S_SEND) && m_ready;
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    msg_done_d = 1'b0;
    pop        = 1'b0;
    if (clr) begin
      state_d = S_IDLE;
      shift_d = '0;
      cnt_d   = '0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            pop = 1'b1;
            if (head.nbytes == 5'd0) begin
              // Fully stripped block: nothing to emit, only the message boundary.
              msg_done_d = head.last;
            end else begin
              state_d = S_SEND;
              shift_d = head.data;
              cnt_d   = head.nbytes;
              last_d  = head.last;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SEND: begin
          if (accept) begin
            shift_d = {shift_q[BLK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            cnt_d   = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
              msg_done_d = last_q;
              if (!fifo_empty && (head.nbytes != 5'd0)) begin
                pop     = 1'b1;
                shift_d = head.data;
                cnt_d   = head.nbytes;
                last_d  = head.last;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              state_d = S_SEND;
            end
          end else begin
            state_d = S_SEND;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    push     = blk_valid && !clr && (!fifo_full || pop);
    m_last_d = (state_d == S_SEND) && (cnt_d == 5'd1) && last_d;
    if (clr) begin
      overflow_d = 1'b0;
    end else if (blk_valid && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // FSM, datapath and output flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      m_last_q   <= 1'b0;
      msg_done_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      m_last_q   <= m_last_d;
      msg_done_q <= msg_done_d;
      overflow_q <= overflow_d;
    end
  end

  assign m_valid  = (state_q == S_SEND);
  assign m_data   = shift_q[BLK_W-1:BLK_W-BYTE_W];
  assign m_last   = m_last_q;
  assign msg_done = msg_done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ofb_pt_serializer.sv
// Scoreboard bench for ofb_pt_serializer: a block-level model queues expected bytes,
// a negedge monitor pops and compares every accepted byte and every msg_done cycle.
`timescale 1ns/1ps
module tb_ofb_pt_serializer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         blk_valid = 1'b0;
  logic [127:0] blk_data = '0;
  logic         blk_last = 1'b0;
  logic [7:0]   m_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;
  logic         msg_done;
  logic         overflow;
  logic         pad_err;

  ofb_pt_serializer #(.DEPTH(2), .AW(1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .blk_valid(blk_valid), .blk_data(blk_data), .blk_last(blk_last),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .msg_done(msg_done), .overflow(overflow), .pad_err(pad_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       mlast;
    logic       eob;
    logic       blast;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   pending_blocks = 0;
  int   zero_done_exp = 0;
  int   done_seen = 0;
  int   acc_run = 0;
  int   max_acc = 0;
  int   ready_mode = 0;
  logic ready_fixed = 1'b1;
  logic exp_pad_err = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef PKCS7_STRIP_EN
  function automatic int model_last_nbytes(input logic [127:0] d, output logic bad);
    int pad;
    logic ok;
    pad = int'(d[7:0]);
    ok  = (pad >= 1) && (pad <= 16);
    if (ok) begin
      for (int k = 0; k < pad; k++) begin
        if (int'(d[8*k +: 8]) != pad) ok = 1'b0;
      end
    end
    bad = !ok;
    return ok ? 16 - pad : 16;
  endfunction
`endif

  // Drives one block for one cycle (call at posedge+1); expected bytes go to the scoreboard.
  task automatic put_block(input logic [127:0] d, input logic l, input bit drop);
    int   nb;
    logic bad;
    nb  = 16;
    bad = 1'b0;
`ifdef PKCS7_STRIP_EN
    if (l) nb = model_last_nbytes(d, bad);
`endif
    blk_valid = 1'b1;
    blk_data  = d;
    blk_last  = l;
    if (!drop) begin
      for (int i = 0; i < nb; i++) begin
        sbq.push_back('{d[127-8*i -: 8], logic'(l && (i == nb-1)), logic'(i == nb-1), l});
      end
      if (nb > 0) pending_blocks++;
      else if (l) zero_done_exp++;
      if (bad) exp_pad_err = 1'b1;
    end
    tick();
    blk_valid = 1'b0;
    blk_last  = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name, output int used);
    used = 0;
    while ((sbq.size() != 0 || m_valid) && used < budget) begin
      tick();
      used++;
    end
    checks++;
    if (sbq.size() != 0 || m_valid) begin
      errors++;
      $display("FAIL %s_drain: actual %0d bytes left required 0", name, sbq.size());
    end
    tick();
    tick();
  endtask

  task automatic flush_model();
    sbq.delete();
    pending_blocks = 0;
    zero_done_exp  = 0;
    exp_pad_err    = 1'b0;
  endtask

  // Sink ready driver, applied slightly after the stimulus phase.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: m_ready = ready_fixed;
        1: m_ready = 1'($urandom_range(0, 1));
        2: m_ready = ~m_ready;
        default: m_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares accepted bytes, hold-during-stall and msg_done timing.
  initial begin
    exp_t       e;
    logic       pend_done = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || clr) begin
        pend_done  = 1'b0;
        prev_stall = 1'b0;
        acc_run    = 0;
      end else begin
        if (msg_done) done_seen++;
        if (msg_done && !pend_done && zero_done_exp > 0) begin
          checks++;
          zero_done_exp--;
        end else begin
          check("msg_done", msg_done, pend_done);
        end
        if (prev_stall) begin
          check("hold_valid", m_valid, 1'b1);
          check("hold_data", m_data, prev_data);
        end
        pend_done = 1'b0;
        if (m_valid && m_ready) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: actual %0h required none", m_data);
          end else begin
            e = sbq.pop_front();
            check("m_data", m_data, e.data);
            check("m_last", m_last, e.mlast);
            pend_done = e.eob && e.blast;
            if (e.eob) pending_blocks--;
          end
          acc_run++;
          if (acc_run > max_acc) max_acc = acc_run;
        end else if (!m_valid) begin
          acc_run = 0;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] b;
    logic [127:0] b1;
    int used;
    int d0;
    int budget;

    b = 128'h00112233445566778899AABBCCDDEEFF;
    tick();
    tick();
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 8'h00);
    check("rst_m_last", m_last, 1'b0);
    check("rst_msg_done", msg_done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_pad_err", pad_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single non-last block, latency and back-to-back bytes.
    max_acc = 0;
    put_block(b, 1'b0, 1'b0);
    check("lat_n1_valid", m_valid, 1'b0);
    tick();
    check("lat_n2_valid", m_valid, 1'b1);
    check("lat_n2_byte0", m_data, 8'h00);
    wait_drain(40, "t1", used);
    check("t1_run", max_acc, 16);

    // Last block: m_last on byte FF, single msg_done.
    d0 = done_seen;
    put_block(b, 1'b1, 1'b0);
    wait_drain(40, "t2", used);
    check("t2_done_count", done_seen, d0 + 1);

    // Alternating ready.
    ready_mode = 2;
    put_block(b, 1'b0, 1'b0);
    wait_drain(60, "t3", used);
    check("t3_span_ok", used <= 36, 1'b1);
    ready_mode = 0;

    // Overflow: shift register plus two FIFO entries, fourth block dropped.
    ready_fixed = 1'b0;
    tick();
    put_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    put_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    put_block({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
    check("ovf_before_drop", overflow, 1'b0);
    put_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1);
    check("ovf_after_drop", overflow, 1'b1);
    max_acc = 0;
    ready_fixed = 1'b1;
    wait_drain(80, "t4", used);
    check("t4_no_gap_run", max_acc, 48);
    check("ovf_sticky", overflow, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("ovf_cleared", overflow, 1'b0);

    // clr aborts a block in flight.
    put_block(b, 1'b1, 1'b0);
    repeat (5) tick();
    clr = 1'b1;
    flush_model();
    tick();
    clr = 1'b0;
    check("clr_abort_valid", m_valid, 1'b0);
    check("clr_abort_data", m_data, 8'h00);

    // clr with blk_valid in the same cycle: block discarded.
    clr = 1'b1;
    blk_valid = 1'b1;
    blk_data = b;
    tick();
    clr = 1'b0;
    blk_valid = 1'b0;
    repeat (3) tick();
    check("clr_wins_valid", m_valid, 1'b0);
    check("clr_wins_ovf", overflow, 1'b0);

    // Asynchronous reset at byte 7 with a second block queued.
    b1 = {$urandom, $urandom, $urandom, $urandom};
    put_block(b1, 1'b0, 1'b0);
    put_block(b, 1'b1, 1'b0);
    repeat (7) tick();
    check("pre_rst_byte7", m_data, b1[71:64]);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", m_valid, 1'b0);
    check("rst_async_data", m_data, 8'h00);
    flush_model();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("rst_fifo_empty", m_valid, 1'b0);
    put_block(b, 1'b1, 1'b0);
    tick();
    check("post_rst_byte0", m_data, 8'h00);
    wait_drain(40, "t6", used);

`ifdef PKCS7_STRIP_EN
    put_block({96'h0123456789ABCDEF01234567, 32'h04040404}, 1'b1, 1'b0);
    wait_drain(40, "pad4", used);
    d0 = done_seen;
    put_block({16{8'h10}}, 1'b1, 1'b0);
    repeat (4) tick();
    check("pad16_done", done_seen, d0 + 1);
    check("pad16_zero", zero_done_exp, 0);
    check("pad_ok_no_err", pad_err, 1'b0);
    put_block({112'h0, 16'h0305}, 1'b1, 1'b0);
    wait_drain(40, "padbad", used);
    check("pad_bad_err", pad_err, 1'b1);
`endif

    // Randomised traffic with random sink stalls; at most two blocks outstanding.
    ready_mode = 1;
    for (int n = 0; n < 40; n++) begin
      budget = 0;
      while (pending_blocks > 1 && budget < 200) begin
        tick();
        budget++;
      end
      check("rand_wait", pending_blocks <= 1, 1'b1);
      repeat ($urandom_range(0, 3)) tick();
      put_block({$urandom, $urandom, $urandom, $urandom}, logic'($urandom_range(0, 2) == 0), 1'b0);
    end
    wait_drain(400, "rand", used);
    ready_mode = 0;

    check("final_overflow", overflow, 1'b0);
    check("final_pad_err", pad_err, exp_pad_err);
    check("final_zero_pending", zero_done_exp, 0);
    check("final_blocks_pending", pending_blocks, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
